// File: rtl/wb_port_arbiter_if.sv
// Register-file write port sharing bus: pipeline writeback side,
// long-latency result side and the register-file write port.
interface wb_port_arbiter_if #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              pl_valid;
  logic [4:0]        pl_rd;
  logic [DATA_W-1:0] pl_data;
  logic              pl_stall;

  logic              lu_valid;
  logic [4:0]        lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;

  logic              reg_we;
  logic [4:0]        reg_rd;
  logic [DATA_W-1:0] reg_wdata;

  logic [CW-1:0]     fifo_count;

  // Arbiter side
  modport slave (
    input  pl_valid, pl_rd, pl_data, lu_valid, lu_rd, lu_data,
    output pl_stall, lu_ready, reg_we, reg_rd, reg_wdata, fifo_count
  );

  // Pipeline / long-latency unit / register file side
  modport master (
    output pl_valid, pl_rd, pl_data, lu_valid, lu_rd, lu_data,
    input  pl_stall, lu_ready, reg_we, reg_rd, reg_wdata, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback stage and a FIFO of long-latency results. Guarantees the FIFO
// head is never starved longer than STARVE_LIMIT cycles and that an older
// queued write to a register always lands before a younger pipeline write.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input logic             clk,
  input logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    G_IDLE,
    G_PIPE,
    G_FIFO
  } grant_t;

  // Entry storage (data path, not reset)
  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

  // Control state
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;

  logic   fifo_empty;
  logic   waw_hit;
  logic   push;
  logic   pop;
  grant_t grant;

  assign fifo_empty = (count == '0);

  // A pipeline write collides with any still-queued write to the same register
  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_rd[i] == bus.pl_rd)) waw_hit = 1'b1;
    end
  end

  // Per-cycle writer selection in priority order
  always_comb begin
    grant = G_IDLE;
    if (rst) begin
      grant = G_IDLE;
    end else if (!fifo_empty && (starve_cnt == SW'(STARVE_LIMIT))) begin
      grant = G_FIFO;
    end else if (bus.pl_valid && (bus.pl_rd != 5'd0) && waw_hit) begin
      grant = G_FIFO;
    end else if (bus.pl_valid) begin
      grant = G_PIPE;
    end else if (!fifo_empty) begin
      grant = G_FIFO;
    end
  end

  // Drive the write port from the granted source; an x0 FIFO entry is dropped
  always_comb begin
    bus.reg_we    = 1'b0;
    bus.reg_rd    = 5'd0;
    bus.reg_wdata = '0;
    case (grant)
      G_PIPE: begin
        bus.reg_we    = 1'b1;
        bus.reg_rd    = bus.pl_rd;
        bus.reg_wdata = bus.pl_data;
      end
      G_FIFO: begin
        bus.reg_we    = (fifo_rd[rd_ptr] != 5'd0);
        bus.reg_rd    = fifo_rd[rd_ptr];
        bus.reg_wdata = fifo_data[rd_ptr];
      end
      default: ;
    endcase
  end

  // Handshake outputs; acceptance depends on occupancy alone
  always_comb begin
    bus.lu_ready   = !rst && (count < CW'(FIFO_DEPTH));
    bus.pl_stall   = bus.pl_valid && (grant == G_FIFO);
    bus.fifo_count = count;
    push           = bus.lu_valid && bus.lu_ready;
    pop            = (grant == G_FIFO);
  end

  // Capture accepted long-latency results into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lu_rd;
      fifo_data[wr_ptr] <= bus.lu_data;
    end
  end

  // Pointers, occupancy, entry-valid flags and the starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_vld   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || fifo_empty) begin
        starve_cnt <= '0;
      end else if ((grant == G_PIPE) && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_wb_port_arbiter;
  localparam int FD  = 2;
  localparam int LIM = 4;
  localparam int CW  = $clog2(FD) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   mis = 0;

  wb_port_arbiter_if #(.FIFO_DEPTH(FD), .DATA_W(32)) bus ();

  wb_port_arbiter #(.FIFO_DEPTH(FD), .STARVE_LIMIT(LIM), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.pl_valid = 1'b0; bus.pl_rd = 5'd0; bus.pl_data = 32'd0;
    bus.lu_valid = 1'b0; bus.lu_rd = 5'd0; bus.lu_data = 32'd0;
  endtask

  task automatic do_reset();
    nxt();
    idle_in();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  function automatic logic [38:0] outv();
    return {bus.reg_we, bus.reg_rd, bus.reg_wdata, bus.pl_stall};
  endfunction

  task automatic test_reset();
    do_reset();
    bus.pl_valid = 1'b1; bus.pl_rd = 5'd3; bus.pl_data = 32'h33;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd4; bus.lu_data = 32'h44;
    @(negedge clk); nxt();
    bus.lu_rd = 5'd5; bus.lu_data = 32'h55;
    @(negedge clk); nxt();
    bus.lu_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.fifo_count !== CW'(2)) begin
      mis++; $display("FAIL reset_prefill: fifo_count got %0d want 2", bus.fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({outv(), bus.lu_ready, bus.fifo_count} !== '0) begin
      mis++; $display("FAIL reset_outputs: got %0h want 0", {outv(), bus.lu_ready, bus.fifo_count});
    end
    nxt();
    idle_in();
    nxt();
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({bus.fifo_count, bus.lu_ready, bus.reg_we} !== {CW'(0), 1'b1, 1'b0}) begin
      mis++; $display("FAIL reset_release: count/ready/we got %0h want %0h",
                      {bus.fifo_count, bus.lu_ready, bus.reg_we}, {CW'(0), 1'b1, 1'b0});
    end
    nxt();
    @(negedge clk);
    vec++;
    if (bus.reg_we !== 1'b0) begin
      mis++; $display("FAIL reset_stale: reg_we got %0b want 0", bus.reg_we);
    end
    nxt();
  endtask

  task automatic test_pipe_only();
    do_reset();
    bus.pl_valid = 1'b1; bus.pl_rd = 5'd5; bus.pl_data = 32'h1234;
    @(negedge clk);
    vec++;
    if (outv() !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin
      mis++; $display("FAIL pipe_only: got %0h want %0h", outv(), {1'b1, 5'd5, 32'h1234, 1'b0});
    end
    nxt();
    idle_in();
  endtask

  task automatic test_drain();
    do_reset();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'hA5A5;
    @(negedge clk);
    vec++;
    if ({bus.reg_we, bus.lu_ready, bus.fifo_count} !== {1'b0, 1'b1, CW'(0)}) begin
      mis++; $display("FAIL drain_accept: we/ready/count got %0h want %0h",
                      {bus.reg_we, bus.lu_ready, bus.fifo_count}, {1'b0, 1'b1, CW'(0)});
    end
    nxt();
    bus.lu_valid = 1'b0;
    @(negedge clk);
    vec++;
    if ({outv(), bus.fifo_count} !== {1'b1, 5'd7, 32'hA5A5, 1'b0, CW'(1)}) begin
      mis++; $display("FAIL drain_write: got %0h want %0h", {outv(), bus.fifo_count},
                      {1'b1, 5'd7, 32'hA5A5, 1'b0, CW'(1)});
    end
    nxt();
    @(negedge clk);
    vec++;
    if ({bus.reg_we, bus.fifo_count} !== {1'b0, CW'(0)}) begin
      mis++; $display("FAIL drain_empty: we/count got %0h want %0h",
                      {bus.reg_we, bus.fifo_count}, {1'b0, CW'(0)});
    end
    nxt();
  endtask

  task automatic test_starvation();
    do_reset();
    bus.pl_valid = 1'b1; bus.pl_rd = 5'd3; bus.pl_data = 32'h33;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
    @(negedge clk); nxt();
    bus.lu_valid = 1'b0;
    for (int k = 1; k <= LIM; k++) begin
      @(negedge clk);
      vec++;
      if (outv() !== {1'b1, 5'd3, 32'h33, 1'b0}) begin
        mis++; $display("FAIL starve_pipe%0d: got %0h want %0h", k, outv(), {1'b1, 5'd3, 32'h33, 1'b0});
      end
      nxt();
    end
    @(negedge clk);
    vec++;
    if (outv() !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
      mis++; $display("FAIL starve_force: got %0h want %0h", outv(), {1'b1, 5'd9, 32'h99, 1'b1});
    end
    nxt();
    @(negedge clk);
    vec++;
    if ({outv(), bus.fifo_count} !== {1'b1, 5'd3, 32'h33, 1'b0, CW'(0)}) begin
      mis++; $display("FAIL starve_resume: got %0h want %0h", {outv(), bus.fifo_count},
                      {1'b1, 5'd3, 32'h33, 1'b0, CW'(0)});
    end
    nxt();
    idle_in();
  endtask

  task automatic test_waw();
    logic [31:0] x12;
    x12 = 32'hx;
    do_reset();
    bus.pl_valid = 1'b1; bus.pl_rd = 5'd3; bus.pl_data = 32'h33;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd12; bus.lu_data = 32'h1;
    @(negedge clk); nxt();
    bus.lu_valid = 1'b0;
    bus.pl_rd = 5'd12; bus.pl_data = 32'h2;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bus.reg_we && bus.reg_rd == 5'd12) x12 = bus.reg_wdata;
      vec++;
      if (k == 0 && outv() !== {1'b1, 5'd12, 32'h1, 1'b1}) begin
        mis++; $display("FAIL waw_old_first: got %0h want %0h", outv(), {1'b1, 5'd12, 32'h1, 1'b1});
      end else if (k == 1 && outv() !== {1'b1, 5'd12, 32'h2, 1'b0}) begin
        mis++; $display("FAIL waw_young_second: got %0h want %0h", outv(), {1'b1, 5'd12, 32'h2, 1'b0});
      end
      nxt();
    end
    vec++;
    if (x12 !== 32'h2) begin
      mis++; $display("FAIL waw_final_x12: got %0h want 2", x12);
    end
    idle_in();
  endtask

  task automatic test_full_rd0();
    do_reset();
    bus.pl_valid = 1'b1; bus.pl_rd = 5'd3; bus.pl_data = 32'h33;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'hDEAD;
    @(negedge clk); nxt();
    bus.lu_rd = 5'd8; bus.lu_data = 32'hBEEF;
    @(negedge clk); nxt();
    bus.lu_rd = 5'd10; bus.lu_data = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if ({bus.lu_ready, bus.fifo_count, outv()} !== {1'b0, CW'(2), 1'b1, 5'd3, 32'h33, 1'b0}) begin
        mis++; $display("FAIL full_hold%0d: got %0h want %0h", k, {bus.lu_ready, bus.fifo_count, outv()},
                        {1'b0, CW'(2), 1'b1, 5'd3, 32'h33, 1'b0});
      end
      nxt();
    end
    @(negedge clk);
    vec++;
    if ({bus.lu_ready, bus.reg_we, bus.pl_stall} !== 3'b001) begin
      mis++; $display("FAIL rd0_pop: ready/we/stall got %b want 001", {bus.lu_ready, bus.reg_we, bus.pl_stall});
    end
    nxt();
    @(negedge clk);
    vec++;
    if ({bus.lu_ready, bus.fifo_count, outv()} !== {1'b1, CW'(1), 1'b1, 5'd3, 32'h33, 1'b0}) begin
      mis++; $display("FAIL full_reopen: got %0h want %0h", {bus.lu_ready, bus.fifo_count, outv()},
                      {1'b1, CW'(1), 1'b1, 5'd3, 32'h33, 1'b0});
    end
    nxt();
    idle_in();
  endtask

  task automatic test_random();
    entry_t      q[$];
    int          starve;
    logic        prev_stall;
    logic        take_fifo, take_pipe, hit, exp_ready;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_we;
    logic [39+CW:0] got, want;
    do_reset();
    q.delete();
    starve = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        rst = 1'b1;
        idle_in();
        nxt();
        rst = 1'b0;
        q.delete();
        starve = 0;
        prev_stall = 1'b0;
      end
      if (!prev_stall) begin
        bus.pl_valid = ($urandom_range(0, 3) != 0);
        bus.pl_rd    = 5'($urandom_range(0, 7));
        bus.pl_data  = $urandom;
      end
      bus.lu_valid = $urandom_range(0, 1);
      bus.lu_rd    = 5'($urandom_range(0, 7));
      bus.lu_data  = $urandom;
      @(negedge clk);
      hit = 1'b0;
      foreach (q[j]) if (q[j].rd == bus.pl_rd) hit = 1'b1;
      take_fifo = 1'b0;
      take_pipe = 1'b0;
      if (q.size() > 0 && starve == LIM)                  take_fifo = 1'b1;
      else if (bus.pl_valid && bus.pl_rd != 5'd0 && hit)  take_fifo = 1'b1;
      else if (bus.pl_valid)                              take_pipe = 1'b1;
      else if (q.size() > 0)                              take_fifo = 1'b1;
      exp_we = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
      if (take_pipe) begin
        exp_we = 1'b1; exp_rd = bus.pl_rd; exp_data = bus.pl_data;
      end else if (take_fifo) begin
        exp_we = (q[0].rd != 5'd0); exp_rd = q[0].rd; exp_data = q[0].data;
      end
      exp_ready = (q.size() < FD);
      want = {exp_we, exp_rd, exp_data, bus.pl_valid && take_fifo, exp_ready, CW'(q.size())};
      got  = {outv(), bus.lu_ready, bus.fifo_count};
      vec++;
      if (got !== want) begin
        mis++; $display("FAIL random_cycle%0d: got %0h want %0h", i, got, want);
      end
      prev_stall = bus.pl_valid && take_fifo;
      if (take_fifo || q.size() == 0) starve = 0;
      else if (take_pipe && starve < LIM) starve++;
      if (take_fifo) void'(q.pop_front());
      if (bus.lu_valid && exp_ready) q.push_back('{bus.lu_rd, bus.lu_data});
      nxt();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_pipe_only();
    test_drain();
    test_starvation();
    test_waw();
    test_full_rd0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
